// File: rtl/reorder_buffer.sv
// Circular reorder buffer between dispatch and retire: allocate at the tail,
// complete by tag, retire the oldest entry in order.
module reorder_buffer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TAG_W   = $clog2(DEPTH),
    parameter int unsigned RD_W    = 5,
    parameter int unsigned WORD_W  = 32,
    localparam int unsigned ENTRY_W = 1 + RD_W + WORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               alloc_valid,
    input  logic [ENTRY_W-1:0] alloc_entry,
    output logic [TAG_W-1:0]   alloc_tag,
    output logic               full,
    output logic               empty,
    output logic [TAG_W:0]     count,
    input  logic               wb_valid,
    input  logic [TAG_W-1:0]   wb_tag,
    input  logic [WORD_W-1:0]  wb_value,
    output logic [ENTRY_W-1:0] rob_head,
    input  logic               rob_decrement
);

    // Entry layout: {ready, rd, value}; ready is the MSB.
    localparam logic [ENTRY_W-1:0] READY_MASK = {1'b1, {(ENTRY_W-1){1'b0}}};

    logic [ENTRY_W-1:0] entries [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [TAG_W-1:0]   head_ptr;
    logic [TAG_W-1:0]   tail_ptr;
    logic [TAG_W:0]     count_q;

    logic               head_ready;
    logic               alloc_ok;
    logic               pop_ok;
    logic               wb_ok;
    logic               clear;

    assign clear      = reset || flush;
    assign full       = (count_q == (TAG_W+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign alloc_tag  = tail_ptr;
    assign head_ready = entries[head_ptr][ENTRY_W-1];
    assign rob_head   = empty ? '0 : entries[head_ptr];

    assign alloc_ok = alloc_valid && !full;
    assign pop_ok   = rob_decrement && !empty && head_ready;
    // A completion aimed at the entry being retired this cycle is dropped.
    assign wb_ok    = wb_valid && valid[wb_tag] && !(pop_ok && (wb_tag == head_ptr));

    always_ff @(posedge clk) begin
        if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
            valid    <= '0;
        end else begin
            if (alloc_ok) begin
                valid[tail_ptr] <= 1'b1;
                tail_ptr        <= tail_ptr + 1'b1;
            end
            if (pop_ok) begin
                valid[head_ptr] <= 1'b0;
                head_ptr        <= head_ptr + 1'b1;
            end
            case ({alloc_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Allocation targets a free slot and writeback only a valid one, so the
    // two writes below never hit the same entry.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (alloc_ok)
                entries[tail_ptr] <= alloc_entry & ~READY_MASK;
            if (wb_ok) begin
                entries[wb_tag][WORD_W-1:0]  <= wb_value;
                entries[wb_tag][ENTRY_W-1]   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table plus hand-written
// sequences for fill, wrap, same-cycle writeback/pop, flush and reset.
module tb_reorder_buffer;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned ENTRY_W = 38;

    logic               clk = 1'b0;
    logic               reset, flush, alloc_valid, wb_valid, rob_decrement;
    logic [ENTRY_W-1:0] alloc_entry;
    logic [TAG_W-1:0]   alloc_tag, wb_tag;
    logic               full, empty;
    logic [TAG_W:0]     count;
    logic [31:0]        wb_value;
    logic [ENTRY_W-1:0] rob_head;

    int n_vec = 0;
    int n_err = 0;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .RD_W(5), .WORD_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_entry(alloc_entry), .alloc_tag(alloc_tag),
        .full(full), .empty(empty), .count(count),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .rob_head(rob_head), .rob_decrement(rob_decrement)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, fl, av;
        logic [4:0]  rd;
        logic [31:0] aval;
        logic        wv;
        logic [3:0]  wt;
        logic [31:0] wval;
        logic        dec;
        logic [3:0]  e_tag;
        logic [4:0]  e_cnt;
        logic        e_full, e_empty;
        logic [4:0]  e_rd;
        logic        e_rdy;
        logic [31:0] e_val;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_head(input string nm, input logic [4:0] rd, input logic rdy, input logic [31:0] val);
        chk({nm, ".rd"},    64'(rob_head[36:32]), 64'(rd));
        chk({nm, ".ready"}, 64'(rob_head[37]),    64'(rdy));
        chk({nm, ".value"}, 64'(rob_head[31:0]),  64'(val));
    endtask

    // Drive one cycle of inputs (alloc ready bit deliberately set: it must be ignored).
    task automatic drive(input logic rst, input logic fl, input logic av, input logic [4:0] rd,
                         input logic [31:0] aval, input logic wv, input logic [3:0] wt,
                         input logic [31:0] wval, input logic dec);
        reset         = rst;
        flush         = fl;
        alloc_valid   = av;
        alloc_entry   = {1'b1, rd, aval};
        wb_valid      = wv;
        wb_tag        = wt;
        wb_value      = wval;
        rob_decrement = dec;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [4:0] q [$];
    logic [4:0] exp_rd;

    initial begin
        reset = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_entry = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_value = '0; rob_decrement = 1'b0;

        //           rst fl av rd aval     wv wt wval    dec  tag cnt full empty rd rdy val
        vecs[0]  = '{1, 0, 0, 0, 0,        0, 0, 0,      0,   0,  0,  0,   1,    0, 0,  0};
        vecs[1]  = '{0, 0, 1, 1, 'h101,    0, 0, 0,      1,   1,  1,  0,   0,    1, 0,  'h101};
        vecs[2]  = '{0, 0, 1, 2, 'h102,    0, 0, 0,      1,   2,  2,  0,   0,    1, 0,  'h101};
        vecs[3]  = '{0, 0, 1, 3, 'h103,    0, 0, 0,      1,   3,  3,  0,   0,    1, 0,  'h101};
        vecs[4]  = '{0, 0, 0, 0, 0,        1, 2, 'hAA,   1,   3,  3,  0,   0,    1, 0,  'h101};
        vecs[5]  = '{0, 0, 0, 0, 0,        1, 0, 'hBB,   1,   3,  3,  0,   0,    1, 1,  'hBB};
        vecs[6]  = '{0, 0, 0, 0, 0,        0, 0, 0,      1,   3,  2,  0,   0,    2, 0,  'h102};
        vecs[7]  = '{0, 0, 0, 0, 0,        0, 0, 0,      1,   3,  2,  0,   0,    2, 0,  'h102};
        vecs[8]  = '{0, 0, 0, 0, 0,        1, 1, 'hCC,   1,   3,  2,  0,   0,    2, 1,  'hCC};
        vecs[9]  = '{0, 0, 0, 0, 0,        0, 0, 0,      1,   3,  1,  0,   0,    3, 1,  'hAA};
        vecs[10] = '{0, 0, 0, 0, 0,        0, 0, 0,      1,   3,  0,  0,   1,    0, 0,  0};
        vecs[11] = '{0, 0, 0, 0, 0,        0, 0, 0,      1,   3,  0,  0,   1,    0, 0,  0};
        vecs[12] = '{0, 0, 0, 0, 0,        1, 7, 'h77,   0,   3,  0,  0,   1,    0, 0,  0};

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].av, vecs[i].rd, vecs[i].aval,
                  vecs[i].wv, vecs[i].wt, vecs[i].wval, vecs[i].dec);
            chk($sformatf("v%0d.tag", i),   64'(alloc_tag), 64'(vecs[i].e_tag));
            chk($sformatf("v%0d.count", i), 64'(count),     64'(vecs[i].e_cnt));
            chk($sformatf("v%0d.full", i),  64'(full),      64'(vecs[i].e_full));
            chk($sformatf("v%0d.empty", i), 64'(empty),     64'(vecs[i].e_empty));
            chk_head($sformatf("v%0d.head", i), vecs[i].e_rd, vecs[i].e_rdy, vecs[i].e_val);
        end

        // Fill to DEPTH, extra alloc ignored, one pop clears full.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fill%0d.tag", i), 64'(alloc_tag), 64'(i));
            drive(0, 0, 1, 5'(i), 32'h200 + 32'(i), 0, 0, 0, 0);
        end
        chk("fill.full",  64'(full),      64'd1);
        chk("fill.count", 64'(count),     64'd16);
        chk("fill.tag",   64'(alloc_tag), 64'd0);
        drive(0, 0, 1, 31, 32'hDEAD, 0, 0, 0, 0);
        chk("over.count", 64'(count),     64'd16);
        chk("over.tag",   64'(alloc_tag), 64'd0);
        chk_head("over.head", 0, 0, 32'h200);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h55, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("pop1.full",  64'(full),      64'd0);
        chk("pop1.count", 64'(count),     64'd15);
        chk_head("pop1.head", 1, 0, 32'h201);

        // Steady state: alloc, writeback next-oldest, pop head every cycle.
        do_reset();
        q.delete();
        for (int n = 0; n < 3; n++) begin
            drive(0, 0, 1, 5'(n), 32'h100 + 32'(n), 0, 0, 0, 0);
            q.push_back(5'(n));
        end
        drive(0, 0, 0, 0, 0, 1, 0, 32'hD000, 0);
        for (int k = 0; k < 40; k++) begin
            exp_rd = q.pop_front();
            chk_head($sformatf("ss%0d.head", k), exp_rd, 1, 32'hD000 + 32'(k));
            chk($sformatf("ss%0d.tag", k), 64'(alloc_tag), 64'((k + 3) % 16));
            drive(0, 0, 1, 5'((k + 3) % 32), 32'h100, 1, 4'((k + 1) % 16),
                  32'hD000 + 32'(k + 1), 1);
            q.push_back(5'((k + 3) % 32));
            chk($sformatf("ss%0d.count", k), 64'(count), 64'd3);
        end

        // Writeback to free tag, then writeback to head while it pops.
        do_reset();
        drive(0, 0, 1, 4, 32'h44, 0, 0, 0, 0);
        drive(0, 0, 1, 5, 32'h55, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 7, 32'h77, 0);
        chk("wbfree.count", 64'(count), 64'd2);
        chk_head("wbfree.head", 4, 0, 32'h44);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h99, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 32'hEE, 1);
        chk("wbpop.count", 64'(count), 64'd1);
        chk_head("wbpop.head", 5, 0, 32'h55);

        // Flush, then reset, with concurrent alloc/writeback/pop.
        for (int m = 0; m < 2; m++) begin
            do_reset();
            for (int i = 0; i < 5; i++)
                drive(0, 0, 1, 5'(10 + i), 32'h300 + 32'(i), 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0, 1, 0, 32'h11, 0);
            drive(m == 1, m == 0, 1, 20, 32'h320, 1, 1, 32'h22, 1);
            chk($sformatf("clr%0d.empty", m), 64'(empty),     64'd1);
            chk($sformatf("clr%0d.count", m), 64'(count),     64'd0);
            chk($sformatf("clr%0d.tag", m),   64'(alloc_tag), 64'd0);
            chk($sformatf("clr%0d.head", m),  64'(rob_head),  64'd0);
            drive(0, 0, 1, 21, 32'h321, 0, 0, 0, 0);
            chk($sformatf("clr%0d.after.count", m), 64'(count), 64'd1);
            chk_head($sformatf("clr%0d.after.head", m), 21, 0, 32'h321);
        end

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer that holds in-flight instructions between dispatch and retire. Dispatch allocates entries at the tail and receives a tag. Writeback marks entries complete by tag. The oldest entry is always presented on `rob_head` for the retire stage, which pops it with `rob_decrement` once `rob_head.ready` is set.

## Interface
- `DEPTH`, 16: number of entries; must be a power of two, at least 2.
- `TAG_W`, `$clog2(DEPTH)`: width of entry tags and pointers.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  discards all entries; synchronous.
- `alloc_valid`  in  1  dispatch requests one entry this cycle.
- `alloc_entry`  in  `rob_entry`  entry contents to store; `ready` is forced to 0 on write.
- `alloc_tag`  out  `TAG_W`  tag (index) assigned if allocation is accepted this cycle; equals the tail pointer.
- `full`  out  1  count == `DEPTH`.
- `empty`  out  1  count == 0.
- `count`  out  `TAG_W+1`  number of occupied entries.
- `wb_valid`  in  1  completion strobe.
- `wb_tag`  in  `TAG_W`  entry being completed.
- `wb_value`  in  `MemoryWord`  result written into that entry's `value` field.
- `rob_head`  out  `rob_entry`  oldest entry; all-zero when empty.
- `rob_decrement`  in  1  retire pops the head entry.

## Operation
- State: `head_ptr`, `tail_ptr` (`TAG_W` bits each, wrap naturally modulo `DEPTH`), `count`, per-entry `valid` bit, entry storage.
- Allocate: accepted when `alloc_valid && !full`.
  - On accept: write `alloc_entry` with `ready=0` at `tail_ptr`, set `valid`, increment `tail_ptr`.
  - When `full`, the request is ignored with no state change. Dispatch must stall on `full`.
  - Allocation does not use a same-cycle pop to bypass `full`.
- Writeback: accepted when `wb_valid && valid[wb_tag]`.
  - On accept: `value <= wb_value` and `ready <= 1` at `wb_tag`.
  - Writeback to an invalid entry is ignored.
  - A second writeback to the same entry overwrites `value`.
- Pop: accepted when `rob_decrement && !empty && rob_head.ready`.
  - On accept: clear `valid[head_ptr]` and increment `head_ptr`.
  - Otherwise `rob_decrement` is ignored.
- Count: alloc-only increments by 1, pop-only decrements by 1, alloc and pop together leave it unchanged.
- Simultaneous events:
  - Writeback to the head entry in the same cycle as its pop is dropped, because the entry is freed.
  - Allocate and writeback can never target the same index, since a writeback to a free slot is ignored.
- Priority: `reset` > `flush` > normal operation. `flush` clears every `valid` bit, both pointers and `count`. Stored data need not be cleared.
- `rob_head`: combinational read of `entry[head_ptr]`, masked to zero when `empty`.

## Timing
- Reset values:
  - `head_ptr=tail_ptr=0`, `count=0`, all `valid=0`.
  - Outputs: `empty=1`, `full=0`, `alloc_tag=0`, `count=0`, `rob_head=0`.
- `alloc_tag`, `full`, `empty`, `count` and `rob_head` are registered-state derived, with no combinational path from any input.
- Allocation into an empty buffer shows on `rob_head` (with `ready=0`) the cycle after accept.
- Writeback: `ready=1` is visible on `rob_head` one cycle after `wb_valid`. There is no same-cycle bypass.
- Pop: the next-oldest entry appears on `rob_head` the cycle after accept. Sustained throughput is one pop and one allocate per cycle.
- Pointer wrap: index `DEPTH-1` increments to 0. `full` and `empty` are distinguished by `count`, never by pointer equality.
- Reset or flush asserted mid-stream: all in-flight entries are dropped at that edge. The next cycle shows the reset values above.

## Test plan
- Reset, then 3 allocs (rd=1,2,3) → `alloc_tag` 0,1,2; `count=3`; `rob_head.rd=1`, `ready=0`; `rob_decrement` held high pops nothing.
- Writeback tags 2 then 0 (value 0xAA, 0xBB), `rob_decrement` held → head retires tag 0 with value 0xBB. Head then stalls on tag 1 until it is written back, after which tags 1 and 2 retire on consecutive cycles.
- Fill `DEPTH` entries → `full=1`; an extra `alloc_valid` is ignored (`count` stays 16, `tail_ptr` 0). Pop one → `full=0` next cycle.
- Steady-state wrap: alloc, writeback and pop every cycle for 40 cycles → tags wrap 15→0; `count` stays constant; retire order matches alloc order.
- Writeback to an unallocated tag 7 with `count=2` → no change. Writeback to the head in the same cycle as its pop → next entry's `ready` is unaffected.
- `flush` with 5 entries and a concurrent alloc/writeback/pop → next cycle `empty=1`, `count=0`, `alloc_tag=0`, `rob_head=0`. Same check with `reset` in place of `flush`.
